cen_sweep_sequencer: RTL and testbench
======================================

Name: cen_sweep_sequencer

Overview:
- Upstream stimulus and checker for the 32-lane parallel-counter STA block.
- Drives that block's cen bus one lane at a time and watches its cout for the all-ones event.
- Measures detection latency per lane; flags lanes that time out or whose cout is stuck high.
- Runs on the same clock domain as the counter block, so no synchronisers are needed.

Parameters:
LANES, 32, number of cen lanes driven
CNT_W, 16, width of each downstream counter; sets the expected latency
GAP_CYCLES, 8, quiet cycles with all cen low before each lane (minimum 6)
TIMEOUT_CYCLES, 65552, maximum RUN cycles before a lane is declared failed
LAT_W, 18, width of the latency counter and lat_value; must hold TIMEOUT_CYCLES

Ports:
clock  input  1  rising-edge clock, same net as the counter block clock
reset_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse that begins a sweep; ignored while busy=1
lane_mask  input  LANES  lanes to test; sampled on the accepted start
cout  input  1  event output of the counter block, sampled directly
cen  output  LANES  registered one-hot (or zero) enable to the counter block
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse at sweep end
pass  output  1  valid from done until the next start; 1 when fail_mask==0
fail_mask  output  LANES  sticky per-lane failure flags, cleared on start
cur_lane  output  $clog2(LANES)  index of the lane under test
lat_valid  output  1  one-cycle pulse when a lane's latency is captured
lat_value  output  LAT_W  RUN-cycle count at detection

Behaviour:
- Reset (asynchronous assert): state=IDLE. All of the following are 0: cen, busy, done, pass, fail_mask, cur_lane, lat_valid, lat_value, internal counters.
- Reset mid-sweep: cen drops in the same cycle; no done pulse is produced.
- State machine:
  - IDLE: on start, latch lane_mask, clear fail_mask, busy<=1, go to SEEK.
  - SEEK: pick the lowest unvisited set bit of the latched mask, load cur_lane, go to QUIET. If no bit remains, go to FIN.
  - QUIET: cen=0, count GAP_CYCLES. At terminal count:
    - cout=1 → set fail_mask[cur_lane], mark the lane visited, go to SEEK (the lane is never enabled);
    - otherwise go to RUN.
  - RUN: cen = one-hot(cur_lane), lat counter increments each cycle starting at 1 on the first sampled edge after cen rises.
    - cout=1 → lat_value<=count, lat_valid pulse, cen<=0 next cycle, mark visited, go to SEEK.
    - count reaches TIMEOUT_CYCLES without cout → set fail bit, lat_valid pulse with lat_value=TIMEOUT_CYCLES, cen<=0, go to SEEK.
  - FIN: done pulse for one cycle, busy<=0, pass<=(fail_mask==0), return to IDLE.
- Expected pass latency with counter block latency of 2 input syncs + count + 2 output regs: lat_value = 2^CNT_W + 4 (65540 at default).
- The lat counter saturates and never wraps.
- cen is at most one-hot at all times; it is never asserted outside RUN.
- lane_mask==0: sweep goes IDLE→SEEK→FIN, done 2 cycles after start, pass=1.
- start while busy: ignored; it neither restarts the sweep nor clears results.
- cout and timeout on the same cycle: cout wins, the lane passes.
- Lanes are tested in ascending index order.

Decomposition:
- Shared package cen_sweep_pkg holds:
  - the state enum (IDLE, SEEK, QUIET, RUN, FIN);
  - a localparam for the latency formula, 2**CNT_W+4.
- One natural sub-module, lowest_set_picker: combinational priority encoder giving the index and valid bit of the lowest set bit in (mask & ~visited).

Test Plan:
- Bench pairs the sequencer with a counter-block model at CNT_W=4, TIMEOUT_CYCLES=40, GAP_CYCLES=8.
- Single lane: lane_mask=0x1, start → cen=0x1 after 8 quiet cycles; lat_value=20, lat_valid once; done; pass=1; fail_mask=0.
- Multi-lane order: lane_mask=0x8000_0005 → cur_lane sequence 0, 2, 31; three lat_value=20 pulses; cen never multi-hot; pass=1.
- Stuck lane: model lane 2 never fires, lane_mask=0x7 → lane 2 lat_value=40 after 40 cycles; fail_mask=0x4; pass=0.
- Stuck cout: force cout=1 throughout QUIET for lane 1 → fail_mask[1]=1; cen[1] never asserted; sweep continues to lane 2.
- Empty mask and reset mid-sweep:
  - lane_mask=0 → done 2 cycles after start, pass=1;
  - reset_n low during RUN → cen=0 immediately; all outputs at reset values; next start works normally.

Source files
------------

// File: rtl/cen_sweep_pkg.sv
// Shared types and constants for the cen sweep sequencer and its helpers.
package cen_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEEK,
        QUIET,
        RUN,
        FIN
    } state_t;

    localparam int DEFAULT_CNT_W = 16;

    // Counter block path: 2 input syncs + 2**CNT_W counts + 2 output registers.
    function automatic int expected_latency(input int cnt_w);
        return (2 ** cnt_w) + 4;
    endfunction

    localparam int EXPECTED_LATENCY = expected_latency(DEFAULT_CNT_W);

endpackage

// File: rtl/lowest_set_picker.sv
// Priority encoder: index of the lowest lane that is requested but not yet visited.
module lowest_set_picker
    import cen_sweep_pkg::*;
#(
    parameter int LANES = 32,
    parameter int IDX_W = $clog2(LANES)
) (
    input  logic [LANES-1:0] mask,
    input  logic [LANES-1:0] visited,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        idx   = '0;
        valid = 1'b0;
        // Scan downwards so the last hit written is the lowest index.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i] && !visited[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cen_sweep_sequencer.sv
// Sweeps the counter block's cen lanes one at a time and measures cout latency per lane.
module cen_sweep_sequencer
    import cen_sweep_pkg::*;
#(
    parameter int LANES          = 32,
    parameter int CNT_W          = DEFAULT_CNT_W,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = expected_latency(CNT_W) + 12,
    parameter int LAT_W          = 18,
    parameter int LANE_W         = $clog2(LANES)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LANES-1:0]  lane_mask,
    input  logic              cout,
    output logic [LANES-1:0]  cen,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [LANES-1:0]  fail_mask,
    output logic [LANE_W-1:0] cur_lane,
    output logic              lat_valid,
    output logic [LAT_W-1:0]  lat_value
);

    localparam int GAP_W = $clog2(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [LAT_W-1:0] LAT_TIMEOUT = LAT_W'(TIMEOUT_CYCLES);

    state_t             state, state_d;
    logic [LANES-1:0]   mask_q, mask_d;
    logic [LANES-1:0]   visited, visited_d;
    logic [GAP_W-1:0]   gap_cnt, gap_d;
    logic [LAT_W-1:0]   lat_cnt, lat_d, lat_inc;
    logic [LANES-1:0]   cen_d, fail_d, lane_onehot;
    logic               busy_d, done_d, pass_d, lat_valid_d;
    logic [LANE_W-1:0]  lane_d, pick_idx;
    logic [LAT_W-1:0]   lat_value_d;
    logic               pick_valid;

    lowest_set_picker #(
        .LANES (LANES)
    ) u_picker (
        .mask    (mask_q),
        .visited (visited),
        .idx     (pick_idx),
        .valid   (pick_valid)
    );

    assign lane_onehot = {{(LANES-1){1'b0}}, 1'b1} << cur_lane;
    assign lat_inc     = (lat_cnt == '1) ? lat_cnt : lat_cnt + LAT_W'(1);

    always_comb begin
        state_d     = state;
        mask_d      = mask_q;
        visited_d   = visited;
        gap_d       = gap_cnt;
        lat_d       = lat_cnt;
        cen_d       = '0;
        busy_d      = busy;
        done_d      = 1'b0;
        pass_d      = pass;
        fail_d      = fail_mask;
        lane_d      = cur_lane;
        lat_valid_d = 1'b0;
        lat_value_d = lat_value;

        unique case (state)
            IDLE: begin
                if (start) begin
                    mask_d    = lane_mask;
                    visited_d = '0;
                    fail_d    = '0;
                    busy_d    = 1'b1;
                    pass_d    = 1'b0;
                    state_d   = SEEK;
                end
            end
            SEEK: begin
                if (pick_valid) begin
                    lane_d  = pick_idx;
                    gap_d   = '0;
                    state_d = QUIET;
                end else begin
                    state_d = FIN;
                end
            end
            QUIET: begin
                if (gap_cnt == GAP_LAST) begin
                    // cout already high with every lane idle means it is stuck; never enable this lane.
                    if (cout) begin
                        fail_d[cur_lane]    = 1'b1;
                        visited_d[cur_lane] = 1'b1;
                        state_d             = SEEK;
                    end else begin
                        cen_d   = lane_onehot;
                        lat_d   = '0;
                        state_d = RUN;
                    end
                end else begin
                    gap_d = gap_cnt + GAP_W'(1);
                end
            end
            RUN: begin
                lat_d = lat_inc;
                if (cout) begin
                    lat_value_d         = lat_inc;
                    lat_valid_d         = 1'b1;
                    visited_d[cur_lane] = 1'b1;
                    state_d             = SEEK;
                end else if (lat_inc >= LAT_TIMEOUT) begin
                    lat_value_d         = LAT_TIMEOUT;
                    lat_valid_d         = 1'b1;
                    fail_d[cur_lane]    = 1'b1;
                    visited_d[cur_lane] = 1'b1;
                    state_d             = SEEK;
                end else begin
                    cen_d = lane_onehot;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (fail_mask == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mask_q    <= '0;
            visited   <= '0;
            gap_cnt   <= '0;
            lat_cnt   <= '0;
            cen       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
            cur_lane  <= '0;
            lat_valid <= 1'b0;
            lat_value <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_d;
            mask_q    <= mask_d;
            visited   <= visited_d;
            gap_cnt   <= gap_d;
            lat_cnt   <= lat_d;
            cen       <= cen_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            fail_mask <= fail_d;
            cur_lane  <= lane_d;
            lat_valid <= lat_valid_d;
            lat_value <= lat_value_d;
        end
    end

endmodule

// File: tb/tb_cen_sweep_sequencer.sv
// Self-checking bench: sequencer driving a behavioural counter-block model with per-lane latency.
module tb_cen_sweep_sequencer;

    localparam int LANES          = 32;
    localparam int CNT_W          = 4;
    localparam int GAP_CYCLES     = 8;
    localparam int TIMEOUT_CYCLES = 40;
    localparam int LAT_W          = 18;
    localparam int PASS_LAT       = (2 ** CNT_W) + 4;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic [LANES-1:0] lane_mask;
    logic             cout;
    logic [LANES-1:0] cen;
    logic             busy;
    logic             done;
    logic             pass;
    logic [LANES-1:0] fail_mask;
    logic [4:0]       cur_lane;
    logic             lat_valid;
    logic [LAT_W-1:0] lat_value;

    cen_sweep_sequencer #(
        .LANES          (LANES),
        .CNT_W          (CNT_W),
        .GAP_CYCLES     (GAP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .LAT_W          (LAT_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .lane_mask (lane_mask),
        .cout      (cout),
        .cen       (cen),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_mask (fail_mask),
        .cur_lane  (cur_lane),
        .lat_valid (lat_valid),
        .lat_value (lat_value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Counter-block model: lane i raises cout so that the sequencer sees it lane_lat[i]
    // cycles after enabling it (0 = never). cstuck_mask lanes show cout high while idle.
    int               lane_lat [LANES];
    int               en_cnt   [LANES];
    logic [LANES-1:0] cstuck_mask = '0;
    bit               fire;

    initial begin
        for (int i = 0; i < LANES; i++) en_cnt[i] = 0;
        cout = 1'b0;
    end

    always @(posedge clock) begin
        fire = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (cen[i]) begin
                en_cnt[i] <= en_cnt[i] + 1;
                if (lane_lat[i] != 0 && en_cnt[i] + 2 >= lane_lat[i]) fire = 1'b1;
            end else begin
                en_cnt[i] <= 0;
            end
        end
        cout <= fire || (busy && cen == '0 && cstuck_mask[cur_lane]);
    end

    // Monitor: collects latency reports and cen hygiene between sweeps.
    int               lat_lane_q [$];
    int               lat_val_q  [$];
    int               multi_hot;
    logic [LANES-1:0] en_seen;

    always @(negedge clock) begin
        if (lat_valid) begin
            lat_lane_q.push_back(int'(cur_lane));
            lat_val_q.push_back(int'(lat_value));
        end
        if ($countones(cen) > 1) multi_hot++;
        en_seen |= cen;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_all_lat(input int lat);
        for (int i = 0; i < LANES; i++) lane_lat[i] = lat;
    endtask

    task automatic check_reset_values(input string name);
        check({name, ".cen"},       cen, '0);
        check({name, ".busy"},      busy, 0);
        check({name, ".done"},      done, 0);
        check({name, ".pass"},      pass, 0);
        check({name, ".fail_mask"}, fail_mask, '0);
        check({name, ".cur_lane"},  cur_lane, 0);
        check({name, ".lat_valid"}, lat_valid, 0);
        check({name, ".lat_value"}, lat_value, 0);
    endtask

    // One full sweep: derive expectations from the lane rules, run it, compare everything.
    task automatic run_sweep(input string name, input logic [LANES-1:0] mask,
                             input logic [LANES-1:0] cstuck, input int poke_at);
        int               exp_cyc;
        logic [LANES-1:0] exp_fail;
        logic [LANES-1:0] exp_en;
        int               exp_lane [$];
        int               exp_lat  [$];
        int               k;
        bit               got;
        int               n;

        exp_cyc  = 2;
        exp_fail = '0;
        exp_en   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) begin
                exp_cyc += 1 + GAP_CYCLES;
                if (cstuck[i]) begin
                    exp_fail[i] = 1'b1;
                end else begin
                    exp_en[i] = 1'b1;
                    exp_lane.push_back(i);
                    if (lane_lat[i] != 0 && lane_lat[i] <= TIMEOUT_CYCLES) begin
                        exp_lat.push_back(lane_lat[i]);
                        exp_cyc += lane_lat[i];
                    end else begin
                        exp_fail[i] = 1'b1;
                        exp_lat.push_back(TIMEOUT_CYCLES);
                        exp_cyc += TIMEOUT_CYCLES;
                    end
                end
            end
        end

        @(posedge clock);
        lat_lane_q.delete();
        lat_val_q.delete();
        multi_hot = 0;
        en_seen   = '0;

        @(negedge clock);
        cstuck_mask = cstuck;
        lane_mask   = mask;
        start       = 1'b1;
        got         = 1'b0;
        k           = 0;
        while (!got && k < exp_cyc + 100) begin
            @(negedge clock);
            k++;
            if (k == 1) begin
                start     = 1'b0;
                lane_mask = $urandom;
            end
            if (k == poke_at) start = 1'b1;
            if (k == poke_at + 1) start = 1'b0;
            if (done) got = 1'b1;
        end

        check({name, ".done_seen"}, got, 1);
        check({name, ".done_cycle"}, k - 1, exp_cyc);
        check({name, ".busy_at_done"}, busy, 0);
        check({name, ".fail_mask"}, fail_mask, exp_fail);
        check({name, ".pass"}, pass, exp_fail == '0);
        check({name, ".lat_pulses"}, lat_lane_q.size(), exp_lane.size());
        n = (lat_lane_q.size() < exp_lane.size()) ? lat_lane_q.size() : exp_lane.size();
        for (int j = 0; j < n; j++) begin
            check({name, ".lat_lane"}, lat_lane_q[j], exp_lane[j]);
            check({name, ".lat_value"}, lat_val_q[j], exp_lat[j]);
        end
        check({name, ".multi_hot"}, multi_hot, 0);
        check({name, ".lanes_enabled"}, en_seen, exp_en);

        @(negedge clock);
        check({name, ".done_one_cycle"}, done, 0);
        check({name, ".pass_held"}, pass, exp_fail == '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [LANES-1:0] rmask;
        logic [LANES-1:0] rstuck;
        int               k;
        bit               saw_done;

        set_all_lat(PASS_LAT);
        reset_n   = 1'b0;
        start     = 1'b0;
        lane_mask = '0;
        repeat (2) @(negedge clock);
        check_reset_values("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        run_sweep("single", 32'h0000_0001, '0, 0);
        run_sweep("order", 32'h8000_0005, '0, 0);

        lane_lat[2] = 0;
        run_sweep("stuck_lane", 32'h0000_0007, '0, 0);
        set_all_lat(PASS_LAT);

        run_sweep("stuck_cout", 32'h0000_0006, 32'h0000_0002, 0);
        run_sweep("empty", '0, '0, 0);
        run_sweep("start_busy", 32'h0000_0003, '0, 5);

        lane_lat[3] = TIMEOUT_CYCLES;
        lane_lat[4] = TIMEOUT_CYCLES + 1;
        run_sweep("tie_timeout", 32'h0000_0018, '0, 0);
        set_all_lat(PASS_LAT);

        // Reset asserted while a lane is running.
        @(negedge clock);
        cstuck_mask = '0;
        lane_mask   = 32'h0000_0002;
        start       = 1'b1;
        @(negedge clock);
        start = 1'b0;
        k = 0;
        while (cen == '0 && k < 40) begin
            @(negedge clock);
            k++;
        end
        check("midrst.cen_up", cen, 32'h0000_0002);
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check_reset_values("midrst");
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (done) saw_done = 1'b1;
        end
        check("midrst.no_done", saw_done, 0);
        reset_n = 1'b1;
        @(negedge clock);
        run_sweep("after_rst", 32'h0000_0001, '0, 0);

        for (int r = 0; r < 4; r++) begin
            rmask  = $urandom & $urandom;
            rstuck = $urandom & $urandom & $urandom;
            for (int i = 0; i < LANES; i++) begin
                case ($urandom_range(0, 5))
                    0:       lane_lat[i] = 0;
                    1:       lane_lat[i] = TIMEOUT_CYCLES;
                    2:       lane_lat[i] = TIMEOUT_CYCLES + 1;
                    3:       lane_lat[i] = $urandom_range(2, TIMEOUT_CYCLES);
                    default: lane_lat[i] = PASS_LAT;
                endcase
            end
            run_sweep($sformatf("random%0d", r), rmask, rstuck, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
